// File: rtl/phase_unwrap.sv
// Phase unwrapper: turns a stream of wrapped Q3.13 angles into a continuous phase accumulator.
// Optional build macro PHASE_UNWRAP_DELTA_EN enables the registered source_delta output.
module phase_unwrap #(
  parameter int PHASE_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          sink_valid,
  input  logic signed [15:0]            sink,
  output logic                          source_valid,
  output logic signed [PHASE_WIDTH-1:0] source_phase,
  output logic signed [15:0]            source_delta
);

  typedef enum logic {PRIME = 1'b0, RUN = 1'b1} state_t;

  localparam logic signed [16:0] PI     = 17'sd25736;
  localparam logic signed [16:0] TWO_PI = 17'sd51472;

  // Fold a raw difference back into [-pi, pi]; exactly +/-pi is left alone.
  function automatic logic signed [16:0] wrap_fix(input logic signed [16:0] d);
    if (d > PI)
      return d - TWO_PI;
    else if (d < -PI)
      return d + TWO_PI;
    else
      return d;
  endfunction

  state_t                         state_q, state_d;
  logic signed [15:0]             prev_q, prev_d;
  logic signed [PHASE_WIDTH-1:0]  acc_q, acc_d;
  logic                           vld_q, vld_d;
  logic signed [16:0]             d_raw, d_fix;

  assign d_raw = 17'(sink) - 17'(prev_q);
  assign d_fix = wrap_fix(d_raw);

`ifdef PHASE_UNWRAP_DELTA_EN
  logic signed [15:0] delta_q, delta_d;
`endif

  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    acc_d   = acc_q;
    vld_d   = 1'b0;
`ifdef PHASE_UNWRAP_DELTA_EN
    delta_d = delta_q;
`endif
    if (sink_valid) begin
      vld_d   = 1'b1;
      prev_d  = sink;
      state_d = RUN;
      // A clear arriving with a sample re-primes on that very sample.
      if (clear || state_q == PRIME) begin
        acc_d = PHASE_WIDTH'(sink);
`ifdef PHASE_UNWRAP_DELTA_EN
        delta_d = '0;
`endif
      end else begin
        acc_d = acc_q + PHASE_WIDTH'(d_fix);
`ifdef PHASE_UNWRAP_DELTA_EN
        delta_d = d_fix[15:0];
`endif
      end
    end else if (clear) begin
      state_d = PRIME;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= PRIME;
      prev_q  <= '0;
      acc_q   <= '0;
      vld_q   <= 1'b0;
`ifdef PHASE_UNWRAP_DELTA_EN
      delta_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      acc_q   <= acc_d;
      vld_q   <= vld_d;
`ifdef PHASE_UNWRAP_DELTA_EN
      delta_q <= delta_d;
`endif
    end
  end

  assign source_valid = vld_q;
  assign source_phase = acc_q;
`ifdef PHASE_UNWRAP_DELTA_EN
  assign source_delta = delta_q;
`else
  assign source_delta = '0;
`endif

endmodule

// File: tb/tb_phase_unwrap.sv
// Self-checking bench for phase_unwrap: a 32-bit and a 17-bit instance share stimulus
// and are compared against an unbounded-integer unwrapping model.
module tb_phase_unwrap;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset, clear, sink_valid;
  logic signed [15:0] sink;
  logic               v32, v17;
  logic signed [31:0] ph32;
  logic signed [16:0] ph17;
  logic signed [15:0] dl32, dl17;

  phase_unwrap #(.PHASE_WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .clear(clear), .sink_valid(sink_valid), .sink(sink),
    .source_valid(v32), .source_phase(ph32), .source_delta(dl32));

  phase_unwrap #(.PHASE_WIDTH(17)) dut17 (
    .clk(clk), .reset(reset), .clear(clear), .sink_valid(sink_valid), .sink(sink),
    .source_valid(v17), .source_phase(ph17), .source_delta(dl17));

  int checks   = 0;
  int failures = 0;

  // Reference model: phase kept as an unbounded integer, narrowed only when compared.
  bit     m_primed;
  int     m_prev;
  longint m_acc;
  int     m_delta;
  bit     m_vld;

  function automatic int unwrap_step(int s, int p);
    int d = s - p;
    if (d > 25736) d -= 51472;
    else if (d < -25736) d += 51472;
    return d;
  endfunction

  function automatic longint wrapw(longint x, int w);
    longint m = longint'(1) << w;
    longint r = x % m;
    if (r < 0) r += m;
    if (r >= m / 2) r -= m;
    return r;
  endfunction

  function automatic int exp_delta();
`ifdef PHASE_UNWRAP_DELTA_EN
    return m_delta;
`else
    return 0;
`endif
  endfunction

  task automatic cyc(input bit v, input bit c, input logic [15:0] s);
    int si;
    sink_valid = v; clear = c; sink = s;
    @(posedge clk); #1;
    si = int'($signed(s));
    m_vld = v;
    if (v) begin
      if (c || !m_primed) begin
        m_acc = si; m_delta = 0;
      end else begin
        m_delta = unwrap_step(si, m_prev);
        m_acc  += m_delta;
      end
      m_prev = si; m_primed = 1'b1;
    end else if (c) begin
      m_primed = 1'b0;
    end
    sink_valid = 1'b0; clear = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; sink_valid = 1'b1; sink = 16'h1234;
    @(posedge clk); #1;
    reset = 1'b0; sink_valid = 1'b0;
    m_primed = 1'b0; m_prev = 0; m_acc = 0; m_delta = 0; m_vld = 1'b0;
  endtask

  task automatic test_reset();
    cyc(1, 0, 16'h3000);
    cyc(1, 0, 16'h5000);
    do_reset();
    checks++;
    if (v32 !== 1'b0 || v17 !== 1'b0) begin
      failures++; $display("FAIL reset_valid got %b/%b want 0", v32, v17);
    end
    checks++;
    if (ph32 !== 32'sd0 || ph17 !== 17'sd0) begin
      failures++; $display("FAIL reset_phase got %0d/%0d want 0", ph32, ph17);
    end
    checks++;
    if (dl32 !== 16'sd0 || dl17 !== 16'sd0) begin
      failures++; $display("FAIL reset_delta got %0d/%0d want 0", dl32, dl17);
    end
    cyc(1, 0, 16'h0700);
    checks++;
    if (v32 !== 1'b1 || ph32 !== 32'sd1792 || dl32 !== 16'sd0) begin
      failures++; $display("FAIL reset_prime got v=%b ph=%0d d=%0d want v=1 ph=1792 d=0", v32, ph32, dl32);
    end
  endtask

  task automatic test_scenarios();
    logic [15:0] a   [3] = '{16'h6000, 16'h9C00, 16'h0000};
    logic [15:0] b   [3] = '{16'h9C00, 16'h6000, 16'h6488};
    int          ph1 [3] = '{24576, -25600, 0};
    int          ph2 [3] = '{25872, -26896, 25736};
    int          dd  [3] = '{1296, -1296, 25736};
    int          wd;
    for (int i = 0; i < 3; i++) begin
      do_reset();
      cyc(1, 0, a[i]);
      checks++;
      if (v32 !== 1'b1 || ph32 !== ph1[i] || ph17 !== ph1[i] || dl32 !== 16'sd0) begin
        failures++; $display("FAIL scen%0d_first got v=%b ph=%0d/%0d d=%0d want ph=%0d d=0",
                             i, v32, ph32, ph17, dl32, ph1[i]);
      end
      cyc(1, 0, b[i]);
`ifdef PHASE_UNWRAP_DELTA_EN
      wd = dd[i];
`else
      wd = 0;
`endif
      checks++;
      if (v32 !== 1'b1 || ph32 !== ph2[i] || ph17 !== ph2[i] || dl32 !== wd || dl17 !== wd) begin
        failures++; $display("FAIL scen%0d_second got v=%b ph=%0d/%0d d=%0d want ph=%0d d=%0d",
                             i, v32, ph32, ph17, dl32, ph2[i], wd);
      end
    end
  endtask

  task automatic test_clear();
    int wd;
    do_reset();
    cyc(1, 0, 16'h6000);
    cyc(1, 0, 16'h9C00);
    cyc(1, 1, 16'h1000);
    checks++;
    if (v32 !== 1'b1 || ph32 !== 32'sd4096 || dl32 !== 16'sd0) begin
      failures++; $display("FAIL clear_prime got v=%b ph=%0d d=%0d want ph=4096 d=0", v32, ph32, dl32);
    end
    cyc(1, 0, 16'h1100);
`ifdef PHASE_UNWRAP_DELTA_EN
    wd = 256;
`else
    wd = 0;
`endif
    checks++;
    if (ph32 !== 32'sd4352 || dl32 !== wd) begin
      failures++; $display("FAIL clear_next got ph=%0d d=%0d want ph=4352 d=%0d", ph32, dl32, wd);
    end
    cyc(0, 1, 16'h7777);
    checks++;
    if (v32 !== 1'b0 || ph32 !== 32'sd4352 || dl32 !== wd) begin
      failures++; $display("FAIL clear_idle got v=%b ph=%0d d=%0d want v=0 ph=4352 d=%0d", v32, ph32, dl32, wd);
    end
    cyc(1, 0, 16'h2000);
    checks++;
    if (v32 !== 1'b1 || ph32 !== 32'sd8192 || dl32 !== 16'sd0) begin
      failures++; $display("FAIL clear_reprime got v=%b ph=%0d d=%0d want ph=8192 d=0", v32, ph32, dl32);
    end
  endtask

  task automatic test_gaps_reset();
    do_reset();
    for (int n = 0; n < 60; n++) begin
      if (n == 30) begin
        do_reset();
        checks++;
        if (v32 !== 1'b0 || ph32 !== 32'sd0 || ph17 !== 17'sd0 || dl32 !== 16'sd0) begin
          failures++; $display("FAIL gap_midreset got v=%b ph=%0d/%0d d=%0d want all 0", v32, ph32, ph17, dl32);
        end
      end
      cyc(1, ($urandom_range(0, 15) == 0), 16'($urandom));
      checks++;
      if (v32 !== m_vld || v17 !== m_vld || ph32 !== wrapw(m_acc, 32) || ph17 !== wrapw(m_acc, 17)
          || dl32 !== exp_delta() || dl17 !== exp_delta()) begin
        failures++; $display("FAIL gap_sample%0d got v=%b ph=%0d/%0d d=%0d want v=%b ph=%0d/%0d d=%0d",
                             n, v32, ph32, ph17, dl32, m_vld, wrapw(m_acc, 32), wrapw(m_acc, 17), exp_delta());
      end
      for (int g = $urandom_range(0, 3); g > 0; g--) begin
        cyc(0, 0, 16'($urandom));
        checks++;
        if (v32 !== 1'b0 || v17 !== 1'b0 || ph32 !== wrapw(m_acc, 32) || dl32 !== exp_delta()) begin
          failures++; $display("FAIL gap_hold%0d got v=%b ph=%0d d=%0d want v=0 ph=%0d d=%0d",
                               n, v32, ph32, dl32, wrapw(m_acc, 32), exp_delta());
        end
      end
    end
  endtask

  task automatic test_wrap17();
    logic [15:0] s = 16'h0000;
    bit saw_wrap = 1'b0;
    do_reset();
    for (int n = 0; n < 16; n++) begin
      cyc(1, 0, s);
      s = s + 16'h4000;
      if (m_acc > 65535 && ph17 < 0) saw_wrap = 1'b1;
      checks++;
      if (ph17 !== wrapw(m_acc, 17) || ph32 !== wrapw(m_acc, 32) || dl17 !== exp_delta()) begin
        failures++; $display("FAIL wrap17_step%0d got ph=%0d/%0d d=%0d want ph=%0d/%0d d=%0d",
                             n, ph17, ph32, dl17, wrapw(m_acc, 17), wrapw(m_acc, 32), exp_delta());
      end
    end
    checks++;
    if (!saw_wrap) begin
      failures++; $display("FAIL wrap17_seen got no negative wrap want wrap, final acc=%0d ph17=%0d", m_acc, ph17);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] s;
    do_reset();
    for (int n = 0; n < 200; n++) begin
      s = ($urandom_range(0, 9) == 0) ? 16'h8000 : 16'($urandom);
      cyc(1, 0, s);
      checks++;
      if (v32 !== 1'b1 || ph32 !== wrapw(m_acc, 32) || ph17 !== wrapw(m_acc, 17)
          || dl32 !== exp_delta() || dl17 !== exp_delta()) begin
        failures++; $display("FAIL b2b_%0d got v=%b ph=%0d/%0d d=%0d want ph=%0d/%0d d=%0d",
                             n, v32, ph32, ph17, dl32, wrapw(m_acc, 32), wrapw(m_acc, 17), exp_delta());
      end
    end
    cyc(0, 0, 16'h0);
    checks++;
    if (v32 !== 1'b0 || ph32 !== wrapw(m_acc, 32)) begin
      failures++; $display("FAIL b2b_tail got v=%b ph=%0d want v=0 ph=%0d", v32, ph32, wrapw(m_acc, 32));
    end
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; sink_valid = 1'b0; sink = '0;
    m_primed = 1'b0; m_prev = 0; m_acc = 0; m_delta = 0; m_vld = 1'b0;
    @(posedge clk); #1;
    do_reset();
    test_reset();
    test_scenarios();
    test_clear();
    test_gaps_reset();
    test_wrap17();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
